// File: rtl/lsu_pkg.sv
// Shared constants for the RV32I load/store unit: funct3 codes, FSM states,
// and byte-lane enable patterns.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] encodes the access size for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request bus and data-memory bus of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_BITS   = 5
);
    logic                  Req_Valid;
    logic                  Req_Ready;
    logic                  Req_Write;
    logic [2:0]            Req_Funct3;
    logic [ADDR_WIDTH-1:0] Req_Addr;
    logic [31:0]           Req_StoreData;
    logic [REG_BITS-1:0]   Req_Rd;

    logic                  Mem_Valid;
    logic                  Mem_Ready;
    logic                  Mem_Write;
    logic [ADDR_WIDTH-1:0] Mem_Addr;
    logic [31:0]           Mem_WrData;
    logic [3:0]            Mem_ByteEn;
    logic                  Mem_RdValid;
    logic [31:0]           Mem_RdData;

    modport slave (
        input  Req_Valid, Req_Write, Req_Funct3, Req_Addr, Req_StoreData, Req_Rd,
        output Req_Ready,
        output Mem_Valid, Mem_Write, Mem_Addr, Mem_WrData, Mem_ByteEn,
        input  Mem_Ready, Mem_RdValid, Mem_RdData
    );

    modport master (
        output Req_Valid, Req_Write, Req_Funct3, Req_Addr, Req_StoreData, Req_Rd,
        input  Req_Ready,
        input  Mem_Valid, Mem_Write, Mem_Addr, Mem_WrData, Mem_ByteEn,
        output Mem_Ready, Mem_RdValid, Mem_RdData
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational access decode: legality, byte enables, store lane replication
// and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_write,
    input  logic [31:0] store_data,
    input  logic [31:0] rd_data,
    output logic        legal,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data,
    output logic [31:0] ld_data
);

    logic [15:0] shifted;

    assign shifted = 16'(rd_data >> {addr_lo, 3'b000});

    always_comb begin
        legal = 1'b0;
        if (is_write)
            legal = funct3 inside {F3_SB, F3_SH, F3_SW};
        else
            legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        case (funct3[1:0])
            SZ_HALF: if (addr_lo[0])      legal = 1'b0;
            SZ_WORD: if (addr_lo != 2'b00) legal = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        byte_en = 4'b0000;
        case (funct3[1:0])
            SZ_BYTE: byte_en = BE_BYTE << addr_lo;
            SZ_HALF: byte_en = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_WORD: byte_en = BE_WORD;
            default: byte_en = 4'b0000;
        endcase
    end

    // Each lane picks its source byte so the memory can simply honour byte_en
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_data[8*gi +: 8] =
                !is_write                ? 8'h00 :
                (funct3[1:0] == SZ_BYTE) ? store_data[7:0] :
                (funct3[1:0] == SZ_HALF) ? store_data[8*(gi%2) +: 8] :
                                           store_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        ld_data = 32'h0;
        case (funct3)
            F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ld_data = {{16{shifted[15]}}, shifted};
            F3_LW:   ld_data = rd_data;
            F3_LBU:  ld_data = {24'h0, shifted[7:0]};
            F3_LHU:  ld_data = {16'h0, shifted};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request, runs the memory handshake and
// writes extended load data back to the register file.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                CLK,
    input  logic                RST,
    load_store_unit_if.slave    bus,
    output logic                WrEn,
    output logic [REG_BITS-1:0] WrAddress,
    output logic [31:0]         WrData,
    output logic                Access_Err,
    output logic                Busy
);

    lsu_state_e            state_reg, state_next;
    logic                  mem_valid_reg, mem_valid_next;
    logic                  mem_write_reg, mem_write_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [31:0]           mem_wr_data_reg, mem_wr_data_next;
    logic [3:0]            mem_byte_en_reg, mem_byte_en_next;
    logic [1:0]            addr_lo_reg, addr_lo_next;
    logic [2:0]            f3_reg, f3_next;
    logic [REG_BITS-1:0]   rd_reg, rd_next;
    logic                  wr_en_reg, wr_en_next;
    logic [31:0]           wr_data_reg, wr_data_next;
    logic                  access_err_reg, access_err_next;

    logic        in_idle;
    logic [1:0]  align_addr_lo;
    logic [2:0]  align_f3;
    logic        align_write;
    logic        align_legal;
    logic [3:0]  align_byte_en;
    logic [31:0] align_wr_data;
    logic [31:0] align_ld_data;

    // One decoder serves both phases: live request while idle, captured request afterwards
    assign in_idle       = (state_reg == ST_IDLE);
    assign align_addr_lo = in_idle ? bus.Req_Addr[1:0] : addr_lo_reg;
    assign align_f3      = in_idle ? bus.Req_Funct3    : f3_reg;
    assign align_write   = in_idle ? bus.Req_Write     : mem_write_reg;

    lsu_align u_align (
        .addr_lo    (align_addr_lo),
        .funct3     (align_f3),
        .is_write   (align_write),
        .store_data (bus.Req_StoreData),
        .rd_data    (bus.Mem_RdData),
        .legal      (align_legal),
        .byte_en    (align_byte_en),
        .wr_data    (align_wr_data),
        .ld_data    (align_ld_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg       <= ST_IDLE;
            mem_valid_reg   <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= 32'h0;
            mem_byte_en_reg <= 4'h0;
            addr_lo_reg     <= 2'b00;
            f3_reg          <= 3'b000;
            rd_reg          <= '0;
            wr_en_reg       <= 1'b0;
            wr_data_reg     <= 32'h0;
            access_err_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_valid_reg   <= mem_valid_next;
            mem_write_reg   <= mem_write_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wr_data_reg <= mem_wr_data_next;
            mem_byte_en_reg <= mem_byte_en_next;
            addr_lo_reg     <= addr_lo_next;
            f3_reg          <= f3_next;
            rd_reg          <= rd_next;
            wr_en_reg       <= wr_en_next;
            wr_data_reg     <= wr_data_next;
            access_err_reg  <= access_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        mem_valid_next   = mem_valid_reg;
        mem_write_next   = mem_write_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wr_data_next = mem_wr_data_reg;
        mem_byte_en_next = mem_byte_en_reg;
        addr_lo_next     = addr_lo_reg;
        f3_next          = f3_reg;
        rd_next          = rd_reg;
        wr_en_next       = 1'b0;
        wr_data_next     = wr_data_reg;
        access_err_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.Req_Valid) begin
                    if (align_legal) begin
                        state_next       = ST_REQ;
                        mem_valid_next   = 1'b1;
                        mem_write_next   = bus.Req_Write;
                        mem_addr_next    = {bus.Req_Addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wr_data_next = align_wr_data;
                        mem_byte_en_next = align_byte_en;
                        addr_lo_next     = bus.Req_Addr[1:0];
                        f3_next          = bus.Req_Funct3;
                        rd_next          = bus.Req_Rd;
                    end else begin
                        state_next      = ST_ERR;
                        access_err_next = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (bus.Mem_Ready) begin
                    mem_valid_next = 1'b0;
                    if (mem_write_reg) begin
                        state_next = ST_IDLE;
                    end else if (bus.Mem_RdValid) begin
                        state_next   = ST_WB;
                        wr_data_next = align_ld_data;
                        wr_en_next   = (rd_reg != '0);
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.Mem_RdValid) begin
                    state_next   = ST_WB;
                    wr_data_next = align_ld_data;
                    wr_en_next   = (rd_reg != '0);
                end
            end
            ST_WB:   state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.Req_Ready  = in_idle;
    assign bus.Mem_Valid  = mem_valid_reg;
    assign bus.Mem_Write  = mem_write_reg;
    assign bus.Mem_Addr   = mem_addr_reg;
    assign bus.Mem_WrData = mem_wr_data_reg;
    assign bus.Mem_ByteEn = mem_byte_en_reg;

    assign WrEn       = wr_en_reg;
    assign WrAddress  = rd_reg;
    assign WrData     = wr_data_reg;
    assign Access_Err = access_err_reg;
    assign Busy       = !in_idle;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized transactions on load_store_unit, checked against a
// size/offset arithmetic model of RV32I load/store behaviour.
module tb_load_store_unit;

    logic        CLK;
    logic        RST;
    logic        wr_en;
    logic [4:0]  wr_address;
    logic [31:0] wr_data;
    logic        access_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    load_store_unit_if #(.ADDR_WIDTH(32), .REG_BITS(5)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .REG_BITS(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .WrEn       (wr_en),
        .WrAddress  (wr_address),
        .WrData     (wr_data),
        .Access_Err (access_err),
        .Busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: access size n bytes at offset off within the word
    function automatic void model(
        input  logic        wr,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] sd,
        input  logic [31:0] rdata,
        output logic        legal,
        output logic [3:0]  be,
        output logic [31:0] wd,
        output logic [31:0] ld
    );
        int n;
        int off;
        bit sgn;
        logic [31:0] v;
        n   = 0;
        sgn = 0;
        off = int'(addr % 4);
        case (f3)
            3'd0: begin n = 1; sgn = 1; end
            3'd1: begin n = 2; sgn = 1; end
            3'd2: n = 4;
            3'd4: if (!wr) n = 1;
            3'd5: if (!wr) n = 2;
            default: n = 0;
        endcase
        legal = (n != 0) && ((off % n) == 0);
        be    = (n == 0) ? 4'h0 : 4'(((1 << n) - 1) << off);
        wd    = 32'h0;
        if (wr && n != 0)
            for (int i = 0; i < 4; i++)
                wd[8*i +: 8] = 8'(sd >> (8 * (i % n)));
        ld = 32'h0;
        if (n == 4) begin
            ld = rdata;
        end else if (n != 0) begin
            v = (rdata >> (8 * off)) & ((32'd1 << (8 * n)) - 32'd1);
            if (sgn && v >= (32'd1 << (8 * n - 1)))
                v = v - (32'd1 << (8 * n));
            ld = v;
        end
    endfunction

    task automatic txn(
        input string       nm,
        input logic        wr,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] sd,
        input logic [4:0]  rd,
        input int          rdy_dly,
        input int          rv_dly,
        input logic [31:0] rdata
    );
        logic        legal;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        model(wr, f3, addr, sd, rdata, legal, be, wd, ld);
        $display("txn %s wr=%0d f3=%0d addr=%h sd=%h rd=%0d rdy=%0d rv=%0d rdata=%h legal=%0d",
                 nm, wr, f3, addr, sd, rd, rdy_dly, rv_dly, rdata, legal);

        chk({nm, ":req_ready_idle"}, bus.Req_Ready, 1);
        bus.Req_Valid     = 1'b1;
        bus.Req_Write     = wr;
        bus.Req_Funct3    = f3;
        bus.Req_Addr      = addr;
        bus.Req_StoreData = sd;
        bus.Req_Rd        = rd;
        step();
        // Request fields change after accept; the unit must ignore them
        bus.Req_Valid     = 1'b0;
        bus.Req_Write     = 1'($urandom);
        bus.Req_Funct3    = 3'($urandom);
        bus.Req_Addr      = $urandom;
        bus.Req_StoreData = $urandom;
        bus.Req_Rd        = 5'($urandom);

        if (!legal) begin
            chk({nm, ":err_pulse"}, access_err, 1);
            chk({nm, ":err_no_mem"}, bus.Mem_Valid, 0);
            chk({nm, ":err_busy"}, busy, 1);
            chk({nm, ":err_not_ready"}, bus.Req_Ready, 0);
            chk({nm, ":err_no_wren"}, wr_en, 0);
            step();
            chk({nm, ":err_clear"}, access_err, 0);
            chk({nm, ":err_ready_back"}, bus.Req_Ready, 1);
            chk({nm, ":err_no_mem2"}, bus.Mem_Valid, 0);
            chk({nm, ":err_no_wren2"}, wr_en, 0);
            return;
        end

        for (int c = 0; c <= rdy_dly; c++) begin
            chk({nm, ":mem_valid"}, bus.Mem_Valid, 1);
            chk({nm, ":mem_addr"}, bus.Mem_Addr, addr & 32'hFFFF_FFFC);
            chk({nm, ":mem_byte_en"}, bus.Mem_ByteEn, be);
            chk({nm, ":mem_wr_data"}, bus.Mem_WrData, wd);
            chk({nm, ":mem_write"}, bus.Mem_Write, wr);
            chk({nm, ":req_busy"}, bus.Req_Ready, 0);
            chk({nm, ":no_err"}, access_err, 0);
            chk({nm, ":req_no_wren"}, wr_en, 0);
            if (c == rdy_dly) begin
                bus.Mem_Ready = 1'b1;
                if (!wr && rv_dly == 0) begin
                    bus.Mem_RdValid = 1'b1;
                    bus.Mem_RdData  = rdata;
                end
            end else begin
                bus.Mem_RdValid = 1'($urandom);
                bus.Mem_RdData  = $urandom;
            end
            step();
            bus.Mem_Ready   = 1'b0;
            bus.Mem_RdValid = 1'b0;
        end

        if (wr) begin
            chk({nm, ":st_mem_drop"}, bus.Mem_Valid, 0);
            chk({nm, ":st_ready"}, bus.Req_Ready, 1);
            chk({nm, ":st_no_wren"}, wr_en, 0);
            return;
        end

        for (int d = 1; d <= rv_dly; d++) begin
            chk({nm, ":wait_mem_drop"}, bus.Mem_Valid, 0);
            chk({nm, ":wait_no_wren"}, wr_en, 0);
            chk({nm, ":wait_busy"}, busy, 1);
            if (d == rv_dly) begin
                bus.Mem_RdValid = 1'b1;
                bus.Mem_RdData  = rdata;
            end
            step();
            bus.Mem_RdValid = 1'b0;
        end

        chk({nm, ":wb_wren"}, wr_en, (rd != 5'd0));
        chk({nm, ":wb_data"}, wr_data, ld);
        if (rd != 5'd0)
            chk({nm, ":wb_addr"}, wr_address, rd);
        chk({nm, ":wb_not_ready"}, bus.Req_Ready, 0);
        chk({nm, ":wb_mem_idle"}, bus.Mem_Valid, 0);
        bus.Mem_RdValid = 1'b1;
        bus.Mem_RdData  = ~rdata;
        step();
        bus.Mem_RdValid = 1'b0;
        chk({nm, ":post_no_wren"}, wr_en, 0);
        chk({nm, ":post_ready"}, bus.Req_Ready, 1);
        chk({nm, ":post_data_held"}, wr_data, ld);
    endtask

    initial begin
        RST               = 1'b0;
        bus.Req_Valid     = 1'b0;
        bus.Req_Write     = 1'b0;
        bus.Req_Funct3    = 3'b000;
        bus.Req_Addr      = 32'h0;
        bus.Req_StoreData = 32'h0;
        bus.Req_Rd        = 5'd0;
        bus.Mem_Ready     = 1'b0;
        bus.Mem_RdValid   = 1'b0;
        bus.Mem_RdData    = 32'h0;

        repeat (2) step();
        chk("rst:req_ready", bus.Req_Ready, 1);
        chk("rst:mem_valid", bus.Mem_Valid, 0);
        chk("rst:mem_write", bus.Mem_Write, 0);
        chk("rst:mem_addr", bus.Mem_Addr, 0);
        chk("rst:mem_wr_data", bus.Mem_WrData, 0);
        chk("rst:mem_byte_en", bus.Mem_ByteEn, 0);
        chk("rst:wr_en", wr_en, 0);
        chk("rst:wr_address", wr_address, 0);
        chk("rst:wr_data", wr_data, 0);
        chk("rst:access_err", access_err, 0);
        chk("rst:busy", busy, 0);
        @(negedge CLK);
        RST = 1'b1;
        step();

        txn("sw",      1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd3, 1, 0, 32'h0);
        txn("sb",      1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 5'd0, 0, 0, 32'h0);
        txn("sh_hi",   1'b1, 3'b001, 32'h0000_0212, 32'h1234_5678, 5'd0, 2, 0, 32'h0);
        txn("lb",      1'b0, 3'b000, 32'h0000_0302, 32'h0,         5'd7, 0, 0, 32'h1280_FF34);
        txn("lbu",     1'b0, 3'b100, 32'h0000_0302, 32'h0,         5'd7, 0, 0, 32'h1280_FF34);
        txn("lh_dly",  1'b0, 3'b001, 32'h0000_0402, 32'h0,         5'd12, 0, 3, 32'h8001_ABCD);
        txn("lhu",     1'b0, 3'b101, 32'h0000_0400, 32'h0,         5'd13, 1, 1, 32'h8001_ABCD);
        txn("lw_err",  1'b0, 3'b010, 32'h0000_0501, 32'h0,         5'd4, 0, 0, 32'h0);
        txn("st_f3_4", 1'b1, 3'b100, 32'h0000_0700, 32'h5555_AAAA, 5'd0, 0, 0, 32'h0);
        txn("lh_odd",  1'b0, 3'b001, 32'h0000_0403, 32'h0,         5'd4, 0, 0, 32'h0);
        txn("lw_x0",   1'b0, 3'b010, 32'h0000_0800, 32'h0,         5'd0, 1, 1, 32'hCAFE_F00D);

        // Reset while the load request is still on the memory bus
        bus.Req_Valid = 1'b1; bus.Req_Write = 1'b0; bus.Req_Funct3 = 3'b010;
        bus.Req_Addr  = 32'h0000_0900; bus.Req_Rd = 5'd9;
        step();
        bus.Req_Valid = 1'b0;
        chk("rstreq:mem_valid_pre", bus.Mem_Valid, 1);
        RST = 1'b0;
        #1;
        chk("rstreq:mem_valid", bus.Mem_Valid, 0);
        chk("rstreq:busy", busy, 0);
        chk("rstreq:ready", bus.Req_Ready, 1);
        @(negedge CLK);
        RST = 1'b1;
        step();

        // Reset while waiting for load data, then late data arrives
        bus.Req_Valid = 1'b1; bus.Req_Write = 1'b0; bus.Req_Funct3 = 3'b010;
        bus.Req_Addr  = 32'h0000_0A00; bus.Req_Rd = 5'd10;
        step();
        bus.Req_Valid = 1'b0;
        bus.Mem_Ready = 1'b1;
        step();
        bus.Mem_Ready = 1'b0;
        chk("rstwait:busy_pre", busy, 1);
        RST = 1'b0;
        #1;
        chk("rstwait:mem_valid", bus.Mem_Valid, 0);
        chk("rstwait:wr_en", wr_en, 0);
        chk("rstwait:busy", busy, 0);
        chk("rstwait:ready", bus.Req_Ready, 1);
        @(negedge CLK);
        RST = 1'b1;
        step();
        bus.Mem_RdValid = 1'b1;
        bus.Mem_RdData  = 32'h1111_2222;
        step();
        bus.Mem_RdValid = 1'b0;
        chk("rstwait:late_no_wren", wr_en, 0);
        chk("rstwait:late_idle", busy, 0);
        step();
        chk("rstwait:late_no_wren2", wr_en, 0);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            a = $urandom;
            txn("rand", 1'($urandom), 3'($urandom), a, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
